// File: rtl/riscv_structures.sv
// Shared RV32 types and architectural constants for the integer datapath.
package riscv_structures;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/rv32_reg_file.sv
// RV32I integer register file: two combinational read ports with write-through
// bypass from the writeback port, x0 hardwired to zero, simulation-only dump.
module rv32_reg_file
  import riscv_structures::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t a1,
  input  reg_addr_t a2,
  input  reg_addr_t a3,
  input  xlen_t     wd,
  input  logic      we3,
  output xlen_t     d1,
  output xlen_t     d2,
  input  logic      dump
);

  xlen_t regs [NREGS];
  logic  wr_live;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we3 && (a3 != '0)) begin
      regs[a3] <= wd;
    end
  end

  // A write landing this cycle is forwarded so decode sees the new value
  // without waiting for the edge; held off while reset owns the array.
  always_comb begin
    wr_live = !rst && we3 && (a3 != '0);
    d1 = '0;
    d2 = '0;
    if (a1 != '0) d1 = (wr_live && (a3 == a1)) ? wd : regs[a1];
    if (a2 != '0) d2 = (wr_live && (a3 == a2)) ? wd : regs[a2];
  end

`ifndef SYNTHESIS
  // Shows pre-edge contents; x0 is printed as zero even before first reset.
  always_ff @(posedge clk) begin
    if (dump) begin
      for (int i = 0; i < NREGS; i++)
        $display("x%02d = 0x%08h", i, (i == 0) ? '0 : regs[i[AW-1:0]]);
    end
  end
`endif

endmodule

// File: tb/tb_rv32_reg_file.sv
// Self-checking bench for rv32_reg_file: directed scenarios plus random traffic
// against an array model of the architectural register state.
module tb_rv32_reg_file;
  import riscv_structures::*;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  reg_addr_t a1 = '0, a2 = '0, a3 = '0;
  xlen_t     wd = '0;
  logic      we3 = 1'b0;
  logic      dump = 1'b0;
  xlen_t     d1, d2;

  rv32_reg_file dut (
    .clk (clk), .rst (rst), .a1 (a1), .a2 (a2), .a3 (a3),
    .wd (wd), .we3 (we3), .d1 (d1), .d2 (d2), .dump (dump)
  );

  always #5 clk = ~clk;

  xlen_t model [32];
  int    n_checks = 0;
  int    n_fails  = 0;

  // Architectural view of a read: x0 is zero, a same-cycle write wins unless
  // reset is asserted, otherwise the stored value.
  function automatic xlen_t ref_read(input reg_addr_t a);
    if (a == 0) return 32'h0;
    if (!rst && we3 && a3 != 0 && a3 == a) return wd;
    return model[a];
  endfunction

  task automatic check(input string tag);
    xlen_t e1, e2;
    e1 = ref_read(a1);
    e2 = ref_read(a2);
    n_checks++;
    assert (d1 === e1) else begin
      n_fails++;
      $error("FAIL %s d1 a1=%0d got=%h exp=%h", tag, a1, d1, e1);
    end
    n_checks++;
    assert (d2 === e2) else begin
      n_fails++;
      $error("FAIL %s d2 a2=%0d got=%h exp=%h", tag, a2, d2, e2);
    end
  endtask

  // Apply one cycle of inputs at negedge, check combinational reads before the
  // edge, then advance the model across the posedge.
  task automatic step(input string tag, input logic r, input logic w,
                      input reg_addr_t aw, input xlen_t d,
                      input reg_addr_t r1, input reg_addr_t r2, input logic dm);
    @(negedge clk);
    rst = r; we3 = w; a3 = aw; wd = d; a1 = r1; a2 = r2; dump = dm;
    #1 check(tag);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && aw != 0) begin
      model[aw] = d;
    end
  endtask

  initial begin
    reg_addr_t ra, rb, rw;
    for (int i = 0; i < 32; i++) model[i] = 'x;

    // x0 reads zero even before any reset
    #2 check("prereset_x0");

    // 1: reset then sweep
    step("reset", 1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 32; i++)
      step("sweep", 0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 0);

    // 2: write / read back
    step("wr_x5", 0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 0);
    step("rd_x5", 0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 0);

    // 3: x0 protection, during and after the edge
    step("x0_wr", 0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 0);
    step("x0_rd", 0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 0);

    // 4: bypass on both ports
    step("x7_init", 0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 0);
    step("bypass", 0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 0);
    step("post_bp", 0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 0);

    // 5: reset priority and no bypass while in reset
    step("x3_init", 0, 1'b1, 5'd3, 32'h99, 5'd0, 5'd0, 0);
    step("rst_prio", 1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd5, 0);
    step("post_rst", 0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 0);

    // 6: dump (output goes to the log only)
    step("wr_x1", 0, 1'b1, 5'd1, 32'h1, 5'd0, 5'd0, 0);
    step("wr_x31", 0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd1, 5'd0, 0);
    step("dump", 0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1);
    step("post_dump", 0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd1, 0);

    // random traffic, reads biased toward the write address
    for (int n = 0; n < 400; n++) begin
      rw = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      step("rand", ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
           rw, $urandom, ra, rb, 0);
    end

    // sweep everything once more against the model
    for (int i = 0; i < 32; i++)
      step("final", 0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
